// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between a core and the data-memory responder
interface dmem_responder_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        MRd;
    logic        MWrt;
    logic [2:0]  FUNC3;
    logic [31:0] IN_ADDR;
    logic [31:0] W_DATA;
    logic        RSP_VALID;
    logic [31:0] R_DATA;
    logic        RSP_ERR;
    modport master (
        output REQ_VALID, MRd, MWrt, FUNC3, IN_ADDR, W_DATA,
        input  REQ_READY, RSP_VALID, R_DATA, RSP_ERR
    );
    modport slave (
        input  REQ_VALID, MRd, MWrt, FUNC3, IN_ADDR, W_DATA,
        output REQ_READY, RSP_VALID, R_DATA, RSP_ERR
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated RV32I data memory with byte-lane stores, extended loads and fault detection
module dmem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic            CLK,
    input  logic            RESET,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mrd_q, mrd_d, mwrt_q, mwrt_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] r_data_q, r_data_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic        f3_ok, al_ok, err, wr_en;
    logic [31:0] word, load_val, wd;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [3:0]  be;
    // Next state and request capture; fields only change when a request is accepted in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mrd_d   = mrd_q;
        mwrt_d  = mwrt_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == IDLE && bus.REQ_VALID) begin
            mrd_d   = bus.MRd;
            mwrt_d  = bus.MWrt;
            f3_d    = bus.FUNC3;
            addr_d  = bus.IN_ADDR;
            wdata_d = bus.W_DATA;
            state_d = WAIT_STATES == 0 ? RESP : WAIT;
            cnt_d   = 4'(WAIT_STATES);
        end else if (state_q == WAIT) begin
            state_d = cnt_q == 4'd1 ? RESP : WAIT;
            cnt_d   = cnt_q - 4'd1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    // Decode the captured request (next-cycle view so a zero-wait store commits on its accept edge)
    always_comb begin
        f3_ok    = mwrt_d ? f3_d inside {3'b000, 3'b001, 3'b010}
                          : f3_d inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        al_ok    = f3_d[1:0] == 2'b01 ? !addr_d[0] : f3_d[1:0] == 2'b10 ? addr_d[1:0] == 2'b00 : 1'b1;
        err      = mrd_d == mwrt_d || !f3_ok || !al_ok || {2'b00, addr_d[31:2]} >= 32'(DEPTH_WORDS);
        word     = mem[addr_d[AW+1:2]];
        lane_b   = word[8*addr_d[1:0] +: 8];
        lane_h   = word[16*addr_d[1] +: 16];
        load_val = f3_d == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
                   f3_d == 3'b100 ? {24'h0, lane_b} :
                   f3_d == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
                   f3_d == 3'b101 ? {16'h0, lane_h} : word;
        be       = f3_d[1:0] == 2'b00 ? 4'b0001 << addr_d[1:0] :
                   f3_d[1:0] == 2'b01 ? (addr_d[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd       = f3_d[1:0] == 2'b00 ? {4{wdata_d[7:0]}} : f3_d[1:0] == 2'b01 ? {2{wdata_d[15:0]}} : wdata_d;
        wr_en    = state_d == RESP && state_q != RESP && mwrt_d && !err;
        rsp_valid_d = state_q == RESP;
        rsp_err_d   = rsp_valid_d && err;
        r_data_d    = rsp_valid_d && !err && mrd_d ? load_val : 32'h0;
        req_ready_d = state_d == IDLE;
    end
    // FSM and registered response outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mrd_q       <= 1'b0;
            mwrt_q      <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            r_data_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mrd_q       <= mrd_d;
            mwrt_q      <= mwrt_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            r_data_q    <= r_data_d;
        end
    end
    // Storage is never reset; stores touch only their enabled byte lanes
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (wr_en && be[i]) mem[addr_d[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
    end
    assign bus.REQ_READY = req_ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.R_DATA    = r_data_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array reference model
module tb_dmem_responder;
    localparam int W = 2, D = 1024, W0 = 0, D0 = 16;
    logic CLK = 1'b0, RESET = 1'b1;
    dmem_responder_if busA ();
    dmem_responder_if bus0 ();
    dmem_responder #(.WAIT_STATES(W), .DEPTH_WORDS(D)) dut (.CLK(CLK), .RESET(RESET), .bus(busA));
    dmem_responder #(.WAIT_STATES(W0), .DEPTH_WORDS(D0)) dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0));
    always #5 CLK = ~CLK;

    int n_tot = 0, n_pass = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: byte-addressed memory, response scheduled W+1 edges after acceptance
    logic [7:0]  mm [4*D];
    int          cyc = 0, commit_at = 0, rsp_at = 0, size;
    bit          have = 0, bad, legal;
    logic        e_ready = 1'b1, e_valid = 1'b0, e_err = 1'b0, r_err;
    logic [31:0] e_data = 32'h0, r_data, v;
    logic        p_ld, p_st;
    logic [2:0]  p_f3;
    logic [31:0] p_addr, p_wd;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            have = 0; e_ready = 1'b1; e_valid = 1'b0; e_err = 1'b0; e_data = 32'h0;
        end else begin
            if (e_ready && busA.REQ_VALID) begin
                have = 1; p_ld = busA.MRd; p_st = busA.MWrt; p_f3 = busA.FUNC3;
                p_addr = busA.IN_ADDR; p_wd = busA.W_DATA;
                commit_at = cyc + W; rsp_at = cyc + W + 1;
            end
            if (have && cyc == commit_at) begin
                size  = p_f3[1:0] == 2'b00 ? 1 : p_f3[1:0] == 2'b01 ? 2 : 4;
                legal = p_st ? p_f3 <= 3'd2 : p_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                bad   = (p_ld == p_st) || !legal || ((p_addr & 32'(size - 1)) != 0) || ((p_addr >> 2) >= 32'(D));
                r_err = bad; r_data = 32'h0;
                if (!bad && p_st) for (int i = 0; i < size; i++) mm[p_addr + 32'(i)] = p_wd[8*i +: 8];
                if (!bad && p_ld) begin
                    v = 32'h0;
                    for (int i = 0; i < size; i++) v = v | (32'(mm[p_addr + 32'(i)]) << (8*i));
                    if (size < 4 && !p_f3[2] && v[8*size-1]) v = v | (32'hFFFFFFFF << (8*size));
                    r_data = v;
                end
            end
            e_valid = have && cyc == rsp_at;
            e_err   = e_valid && r_err;
            e_data  = e_valid ? r_data : 32'h0;
            if (e_valid) have = 0;
            e_ready = !have;
            cyc++;
        end
    end

    // Every-cycle comparison of the whole response bus against the model
    always @(negedge CLK)
        check("cycle", {29'h0, busA.REQ_READY, busA.RSP_VALID, busA.RSP_ERR, busA.R_DATA},
              {29'h0, e_ready, e_valid, e_err, e_data});

    logic rdyA = 1'b1;
    always @(negedge CLK) rdyA = busA.REQ_READY;

    task automatic req(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] d,
                       output int lat, output int lowc);
        int n = 0;
        busA.MRd = ld; busA.MWrt = st; busA.FUNC3 = f3; busA.IN_ADDR = a; busA.W_DATA = wd;
        busA.REQ_VALID = 1'b1;
        do begin @(posedge CLK); n++; end while (!rdyA && n < 50);
        #1;
        busA.REQ_VALID = 1'b0; busA.MRd = 1'($urandom_range(0, 1)); busA.MWrt = 1'($urandom_range(0, 1));
        busA.FUNC3 = 3'($urandom_range(0, 7)); busA.IN_ADDR = $urandom; busA.W_DATA = $urandom;
        lat = 0; lowc = 0; err = 1'b0; d = 32'h0;
        if (!rdyA) begin check("accept_timeout", 64'(rdyA), 64'd1); return; end
        do begin
            @(negedge CLK); lat++;
            if (!busA.REQ_READY) lowc++;
        end while (!busA.RSP_VALID && lat < 50);
        if (!busA.RSP_VALID) check("rsp_timeout", 64'(busA.RSP_VALID), 64'd1);
        err = busA.RSP_ERR; d = busA.R_DATA; lat = lat - 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic        e, r0, st, ld;
    logic [31:0] d, a;
    logic [2:0]  f3;
    logic [2:0]  lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int          l, lc, nv, acc, nr, g, sz;
    int          rt [4] = '{0, 0, 0, 0};
    initial begin
        busA.REQ_VALID = 1'b0; busA.MRd = 1'b0; busA.MWrt = 1'b0; busA.FUNC3 = 3'b0; busA.IN_ADDR = 32'h0; busA.W_DATA = 32'h0;
        bus0.REQ_VALID = 1'b0; bus0.MRd = 1'b0; bus0.MWrt = 1'b0; bus0.FUNC3 = 3'b0; bus0.IN_ADDR = 32'h0; bus0.W_DATA = 32'h0;
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_state", {29'h0, busA.REQ_READY, busA.RSP_VALID, busA.RSP_ERR, busA.R_DATA}, {29'h0, 1'b1, 1'b0, 1'b0, 32'h0});
        #2 RESET = 1'b1;
        for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 3'b010, 32'(4*i), 32'hC0DE0000 | 32'(i), e, d, l, lc);
        req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, e, d, l, lc);
        check("sw_latency", 64'(l), 64'(W + 1));
        check("sw_ready_low", 64'(lc), 64'(W + 1));
        check("sw_rsp", {e, d}, 33'h0);
        req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, e, d, l, lc);
        check("lw_latency", 64'(l), 64'(W + 1));
        check("lw_ready_low", 64'(lc), 64'(W + 1));
        check("lw_10", {e, d}, {1'b0, 32'hDEADBEEF});
        req(1'b0, 1'b1, 3'b000, 32'h12, 32'h0000005A, e, d, l, lc);
        req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, e, d, l, lc);
        check("sb_lw_10", {e, d}, {1'b0, 32'hDE5ABEEF});
        req(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, e, d, l, lc);
        check("lb_13", {e, d}, {1'b0, 32'hFFFFFFDE});
        req(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, e, d, l, lc);
        check("lbu_13", {e, d}, {1'b0, 32'h000000DE});
        req(1'b1, 1'b0, 3'b010, 32'h11, 32'h0, e, d, l, lc);
        check("lw_11_err", {e, d}, {1'b1, 32'h0});
        req(1'b0, 1'b1, 3'b001, 32'h23, 32'h0000FFFF, e, d, l, lc);
        check("sh_23_err", {e, d}, {1'b1, 32'h0});
        req(1'b1, 1'b0, 3'b010, 32'(4*D), 32'h0, e, d, l, lc);
        check("lw_oob_err", {e, d}, {1'b1, 32'h0});
        req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, e, d, l, lc);
        check("lw_20_kept", {e, d}, {1'b0, 32'hC0DE0008});
        req(1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001, e, d, l, lc);
        req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, e, d, l, lc);
        check("lh_22", {e, d}, {1'b0, 32'hFFFF8001});
        req(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, e, d, l, lc);
        check("lhu_22", {e, d}, {1'b0, 32'h00008001});
        req(1'b1, 1'b1, 3'b010, 32'h0, 32'h11111111, e, d, l, lc);
        check("both_err", {e, d}, {1'b1, 32'h0});
        req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, e, d, l, lc);
        check("none_err", {e, d}, {1'b1, 32'h0});
        req(1'b0, 1'b1, 3'b100, 32'h0, 32'h22222222, e, d, l, lc);
        check("sbu_err", {e, d}, {1'b1, 32'h0});
        req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, e, d, l, lc);
        check("ld_f3_err", {e, d}, {1'b1, 32'h0});
        req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, e, d, l, lc);
        check("lw_0_kept", {e, d}, {1'b0, 32'hC0DE0000});
        // store aborted by reset while waiting
        busA.MRd = 1'b0; busA.MWrt = 1'b1; busA.FUNC3 = 3'b010; busA.IN_ADDR = 32'h30; busA.W_DATA = 32'h12345678;
        busA.REQ_VALID = 1'b1;
        nv = 0;
        do begin @(posedge CLK); nv++; end while (!rdyA && nv < 50);
        #1 busA.REQ_VALID = 1'b0;
        @(negedge CLK);
        #1 RESET = 1'b0;
        nv = 0;
        @(negedge CLK);
        if (busA.RSP_VALID) nv++;
        #1 RESET = 1'b1;
        repeat (6) begin @(negedge CLK); if (busA.RSP_VALID) nv++; end
        check("rst_no_rsp", 64'(nv), 64'd0);
        req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, e, d, l, lc);
        check("rst_lw_30", {e, d}, {1'b0, 32'hC0DE000C});
        check("rst_latency", 64'(l), 64'(W + 1));
        // zero-wait instance with REQ_VALID held high for three stores
        bus0.MRd = 1'b0; bus0.MWrt = 1'b1; bus0.FUNC3 = 3'b010; bus0.IN_ADDR = 32'h0; bus0.W_DATA = 32'h11111111;
        bus0.REQ_VALID = 1'b1;
        acc = 0; nr = 0;
        for (int c = 0; c < 12; c++) begin
            r0 = bus0.REQ_READY;
            if (bus0.RSP_VALID) begin
                if (nr < 4) rt[nr] = c;
                nr++;
                check("w0_rsp", {bus0.RSP_ERR, bus0.R_DATA}, 33'h0);
            end
            @(posedge CLK);
            #1;
            if (r0 && bus0.REQ_VALID) begin
                acc++;
                bus0.IN_ADDR = 32'(4*acc); bus0.W_DATA = 32'h11111111 * 32'(acc + 1);
                if (acc == 3) bus0.REQ_VALID = 1'b0;
            end
            @(negedge CLK);
        end
        check("w0_accepts", 64'(acc), 64'd3);
        check("w0_count", 64'(nr), 64'd3);
        check("w0_gap1", 64'(rt[1] - rt[0]), 64'd2);
        check("w0_gap2", 64'(rt[2] - rt[1]), 64'd2);
        // randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 300; t++) begin
            g = $urandom_range(0, 2);
            repeat (g) @(negedge CLK);
            if ($urandom_range(0, 9) < 7) begin
                st = 1'($urandom_range(0, 1)); ld = !st;
                f3 = st ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
                sz = 1 << f3[1:0];
                a  = 32'($urandom_range(0, 63)) & ~32'(sz - 1);
            end else begin
                ld = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                a  = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : $urandom;
            end
            req(ld, st, f3, a, $urandom, e, d, l, lc);
        end
        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
